// File: rtl/cordic_iter_engine.sv
// Iterative multi-mode CORDIC engine: one micro-rotation per clock using an angle ROM built at elaboration.
// Circular, hyperbolic and linear modes, rotation or vectoring, with a sticky overflow flag per operation.
module cordic_iter_engine #(
    parameter int p_WIDTH    = 32,
    parameter int p_FRAC     = p_WIDTH - 3,
    parameter int p_MAX_ITER = p_WIDTH - 4,
    localparam int ITW       = $clog2(p_MAX_ITER + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [1:0]         s_mode,
    input  logic               s_vect,
    input  logic [ITW-1:0]     s_iters,
    input  logic [p_WIDTH-1:0] s_x,
    input  logic [p_WIDTH-1:0] s_y,
    input  logic [p_WIDTH-1:0] s_z,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [p_WIDTH-1:0] m_x,
    output logic [p_WIDTH-1:0] m_y,
    output logic [p_WIDTH-1:0] m_z,
    output logic               m_ovf,
    output logic               m_err
);
    localparam int SW = $clog2(p_WIDTH);
    localparam int RW = SW + 3;
    localparam logic [1:0] MODE_CIRC = 2'b00;
    localparam logic [1:0] MODE_HYP  = 2'b01;
    localparam logic [1:0] MODE_LIN  = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;
    localparam logic [ITW-1:0] C_MAX_ITER = ITW'(p_MAX_ITER);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t r_state, w_state_nxt;
    logic                      w_accept;
    logic signed [p_WIDTH-1:0] r_x, r_y, r_z;
    logic [1:0]                r_mode;
    logic                      r_vect;
    logic [ITW-1:0]            r_cnt, r_last, w_iters_eff;
    logic [SW-1:0]             r_shift;
    logic [RW-1:0]             r_rep;
    logic                      r_rep_done;
    logic                      r_s_ready, r_ovf, r_err;

    logic signed [p_WIDTH-1:0] w_rom_circ [p_WIDTH];
    logic signed [p_WIDTH-1:0] w_rom_hyp  [p_WIDTH];
    logic signed [p_WIDTH-1:0] w_rom_lin  [p_WIDTH];

    // atanh is expanded through ln; entry 0 of the hyperbolic table is never addressed.
    for (genvar g = 0; g < p_WIDTH; g++) begin : g_rom
        localparam real C_SCALE = 2.0 ** p_FRAC;
        localparam real C_T     = 2.0 ** (-g);
        localparam real C_TH    = (g == 0) ? 0.5 : C_T;
        localparam logic [p_WIDTH-1:0] C_CIRC = p_WIDTH'($rtoi($atan(C_T) * C_SCALE + 0.5));
        localparam logic [p_WIDTH-1:0] C_HYP  =
            p_WIDTH'($rtoi(0.5 * $ln((1.0 + C_TH) / (1.0 - C_TH)) * C_SCALE + 0.5));
        localparam logic [p_WIDTH-1:0] C_LIN  = p_WIDTH'($rtoi(C_T * C_SCALE + 0.5));
        assign w_rom_circ[g] = C_CIRC;
        assign w_rom_hyp[g]  = (g == 0) ? '0 : C_HYP;
        assign w_rom_lin[g]  = C_LIN;
    end

    logic                      w_dpos, w_x_sub, w_y_sub, w_z_sub, w_step_ovf;
    logic signed [p_WIDTH-1:0] w_xsh, w_ysh, w_ang;
    logic        [p_WIDTH:0]   w_x_ext, w_y_ext, w_z_ext;

    always_comb begin
        w_dpos  = r_vect ? r_y[p_WIDTH-1] : ~r_z[p_WIDTH-1];
        w_xsh   = r_y >>> r_shift;
        w_ysh   = r_x >>> r_shift;
        case (r_mode)
            MODE_HYP: w_ang = w_rom_hyp[r_shift];
            MODE_LIN: w_ang = w_rom_lin[r_shift];
            default:  w_ang = w_rom_circ[r_shift];
        endcase
        w_x_sub = (r_mode == MODE_CIRC) ? w_dpos : ~w_dpos;
        w_y_sub = ~w_dpos;
        w_z_sub = w_dpos;
        // One guard bit: overflow shows as disagreement between the top two bits.
        w_x_ext = w_x_sub ? ({r_x[p_WIDTH-1], r_x} - {w_xsh[p_WIDTH-1], w_xsh})
                          : ({r_x[p_WIDTH-1], r_x} + {w_xsh[p_WIDTH-1], w_xsh});
        w_y_ext = w_y_sub ? ({r_y[p_WIDTH-1], r_y} - {w_ysh[p_WIDTH-1], w_ysh})
                          : ({r_y[p_WIDTH-1], r_y} + {w_ysh[p_WIDTH-1], w_ysh});
        w_z_ext = w_z_sub ? ({r_z[p_WIDTH-1], r_z} - {w_ang[p_WIDTH-1], w_ang})
                          : ({r_z[p_WIDTH-1], r_z} + {w_ang[p_WIDTH-1], w_ang});
        w_step_ovf = ((r_mode != MODE_LIN) && (w_x_ext[p_WIDTH] ^ w_x_ext[p_WIDTH-1]))
                   | (w_y_ext[p_WIDTH] ^ w_y_ext[p_WIDTH-1])
                   | (w_z_ext[p_WIDTH] ^ w_z_ext[p_WIDTH-1]);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_iters_eff = (s_iters == '0 || s_iters > C_MAX_ITER) ? C_MAX_ITER : s_iters;
        case (r_state)
            ST_IDLE: begin
                if (s_valid && r_s_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (s_mode == MODE_RSVD) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN:  if (r_cnt == r_last) w_state_nxt = ST_DONE;
            ST_DONE: if (m_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_s_ready  <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_z        <= '0;
            r_mode     <= MODE_CIRC;
            r_vect     <= 1'b0;
            r_cnt      <= '0;
            r_last     <= '0;
            r_shift    <= '0;
            r_rep      <= '0;
            r_rep_done <= 1'b0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_s_ready <= (w_state_nxt == ST_IDLE);
            if (w_accept) begin
                r_x        <= s_x;
                r_y        <= s_y;
                r_z        <= s_z;
                r_mode     <= s_mode;
                r_vect     <= s_vect;
                r_cnt      <= '0;
                r_last     <= w_iters_eff - ITW'(1);
                r_shift    <= (s_mode == MODE_HYP) ? SW'(1) : '0;
                r_rep      <= RW'(4);
                r_rep_done <= 1'b0;
                r_ovf      <= 1'b0;
                r_err      <= (s_mode == MODE_RSVD);
            end else if (r_state == ST_RUN) begin
                if (r_mode != MODE_LIN) r_x <= w_x_ext[p_WIDTH-1:0];
                r_y   <= w_y_ext[p_WIDTH-1:0];
                r_z   <= w_z_ext[p_WIDTH-1:0];
                r_ovf <= r_ovf | w_step_ovf;
                r_cnt <= r_cnt + ITW'(1);
                // Hyperbolic repeats shifts 4, 13, 40, ... (k -> 3k+1) once each.
                if (r_mode == MODE_HYP && {{(RW-SW){1'b0}}, r_shift} == r_rep && !r_rep_done) begin
                    r_rep_done <= 1'b1;
                end else begin
                    if (r_shift != SW'(p_WIDTH - 1)) r_shift <= r_shift + SW'(1);
                    if (r_rep_done) begin
                        r_rep_done <= 1'b0;
                        if (r_rep <= RW'(p_WIDTH)) r_rep <= RW'(3) * r_rep + RW'(1);
                    end
                end
            end
        end
    end

    assign s_ready = r_s_ready;
    assign m_valid = (r_state == ST_DONE);
    assign m_x     = r_x;
    assign m_y     = r_y;
    assign m_z     = r_z;
    assign m_ovf   = r_ovf;
    assign m_err   = r_err;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Bench for cordic_iter_engine: directed numeric cases against closed-form values and
// randomized operations against a bit-exact arithmetic reference model.
module tb_cordic_iter_engine;
    localparam int  W    = 32;
    localparam int  MAXI = 28;
    localparam int  ITW  = 5;
    localparam real SC   = 536870912.0;
    localparam real PI   = 3.14159265358979;
    localparam real TOL  = 128.0;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_vect = 1'b0;
    logic           m_ready = 1'b0;
    logic [1:0]     s_mode = 2'b00;
    logic [ITW-1:0] s_iters = '0;
    logic [W-1:0]   s_x = '0, s_y = '0, s_z = '0;
    logic           s_ready, m_valid, m_ovf, m_err;
    logic [W-1:0]   m_x, m_y, m_z;

    int checks = 0;
    int failures = 0;

    logic signed [W-1:0] o_x, o_y, o_z;
    logic                o_ovf, o_err;
    int                  o_lat;
    longint              e_x, e_y, e_z;
    bit                  e_ovf, e_err;

    always #5 clk = ~clk;

    cordic_iter_engine dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_mode(s_mode), .s_vect(s_vect),
        .s_iters(s_iters), .s_x(s_x), .s_y(s_y), .s_z(s_z),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_x(m_x), .m_y(m_y), .m_z(m_z), .m_ovf(m_ovf), .m_err(m_err)
    );

    function automatic logic signed [W-1:0] fx(input real r);
        return $rtoi(r * SC + ((r >= 0.0) ? 0.5 : -0.5));
    endfunction

    function automatic real lsb_err(input logic signed [W-1:0] v, input real e);
        real d;
        d = $itor(v) - e * SC;
        return (d < 0.0) ? -d : d;
    endfunction

    function automatic int eff_n(input int iters);
        return (iters == 0 || iters > MAXI) ? MAXI : iters;
    endfunction

    function automatic int shift_at(input int mode, input int k);
        int s, pos;
        if (mode != 1) return (k > 31) ? 31 : k;
        s = 1;
        pos = 0;
        while (pos < 1000) begin
            if (pos == k) return (s > 31) ? 31 : s;
            pos++;
            if (s == 4 || s == 13 || s == 40 || s == 121) begin
                if (pos == k) return (s > 31) ? 31 : s;
                pos++;
            end
            s++;
        end
        return 31;
    endfunction

    function automatic longint rom_val(input int mode, input int s);
        real t, v;
        t = 2.0 ** (-s);
        if (mode == 0) v = $atan(t);
        else if (mode == 1) v = (s == 0) ? 0.0 : 0.5 * $ln((1.0 + t) / (1.0 - t));
        else v = t;
        return longint'($rtoi(v * SC + 0.5));
    endfunction

    function automatic real gain(input int mode, input int n);
        real g, t;
        g = 1.0;
        for (int k = 0; k < n; k++) begin
            t = 2.0 ** (-2 * shift_at(mode, k));
            g = g * $sqrt((mode == 0) ? (1.0 + t) : (1.0 - t));
        end
        return g;
    endfunction

    function automatic longint wrap32(input longint v);
        return longint'(int'(v));
    endfunction

    // Reference: the micro-rotation equations in wide integers, wrap and overflow applied afterwards.
    task automatic model(input int mode, input bit vect, input int iters,
                         input logic signed [W-1:0] x0, y0, z0);
        longint x, y, z, xn, yn, zn;
        int d, s;
        x = longint'(x0); y = longint'(y0); z = longint'(z0);
        e_ovf = 1'b0;
        e_err = (mode == 3);
        if (mode != 3) begin
            for (int k = 0; k < eff_n(iters); k++) begin
                s = shift_at(mode, k);
                d = (vect ? (y < 0) : (z >= 0)) ? 1 : -1;
                if (mode == 0)      xn = x - d * (y >>> s);
                else if (mode == 1) xn = x + d * (y >>> s);
                else                xn = x;
                yn = y + d * (x >>> s);
                zn = z - d * rom_val(mode, s);
                if (xn != wrap32(xn) || yn != wrap32(yn) || zn != wrap32(zn)) e_ovf = 1'b1;
                x = wrap32(xn); y = wrap32(yn); z = wrap32(zn);
            end
        end
        e_x = x; e_y = y; e_z = z;
    endtask

    // Called at a negedge; returns at the negedge where m_valid is first seen.
    task automatic start_op(input int mode, input bit vect, input int iters,
                            input logic signed [W-1:0] x, y, z);
        int guard;
        guard = 0;
        while (!s_ready && guard < 100) begin @(negedge clk); guard++; end
        checks++;
        if (!s_ready) begin
            failures++;
            $display("FAIL start_wait s_ready got=%0b exp=1", s_ready);
        end
        s_valid = 1'b1; s_mode = mode[1:0]; s_vect = vect; s_iters = iters[ITW-1:0];
        s_x = x; s_y = y; s_z = z;
        @(negedge clk);
        s_valid = 1'b0; s_mode = 2'($urandom); s_vect = 1'($urandom);
        s_x = $urandom; s_y = $urandom; s_z = $urandom;
        o_lat = 1;
        while (!m_valid && o_lat < 100) begin @(negedge clk); o_lat++; end
        checks++;
        if (!m_valid) begin
            failures++;
            $display("FAIL result_wait m_valid got=%0b exp=1 after %0d cycles", m_valid, o_lat);
        end
        o_x = m_x; o_y = m_y; o_z = m_z; o_ovf = m_ovf; o_err = m_err;
    endtask

    task automatic finish_op();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({s_ready, m_valid, m_ovf, m_err} !== 4'b0000 || {m_x, m_y, m_z} !== '0) begin
            failures++;
            $display("FAIL reset_state got rdy=%0b vld=%0b ovf=%0b err=%0b x=%0h y=%0h z=%0h exp all 0",
                     s_ready, m_valid, m_ovf, m_err, m_x, m_y, m_z);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release s_ready got=%0b exp=1", s_ready);
        end
    endtask

    task automatic test_circular();
        logic signed [W-1:0] xi;
        real k;
        k = gain(0, MAXI);
        xi = fx(0.607253);
        start_op(0, 1'b0, 0, xi, 0, fx(PI / 4.0));
        model(0, 1'b0, 0, xi, 0, fx(PI / 4.0));
        finish_op();
        checks++;
        if (o_lat != 29) begin
            failures++;
            $display("FAIL circ_rot_latency got=%0d exp=29", o_lat);
        end
        checks++;
        if (lsb_err(o_x, $itor(xi) / SC * k * $cos(PI / 4.0)) > TOL ||
            lsb_err(o_y, $itor(xi) / SC * k * $sin(PI / 4.0)) > TOL || lsb_err(o_z, 0.0) > TOL) begin
            failures++;
            $display("FAIL circ_rot_value got x=%0d y=%0d z=%0d exp x~y~%0d z~0",
                     o_x, o_y, o_z, fx($itor(xi) / SC * k * 0.70710678));
        end
        checks++;
        if ({o_x, o_y, o_z, o_ovf, o_err} !== {e_x[31:0], e_y[31:0], e_z[31:0], e_ovf, 1'b0}) begin
            failures++;
            $display("FAIL circ_rot_exact got %0d %0d %0d ovf=%0b err=%0b exp %0d %0d %0d ovf=%0b err=0",
                     o_x, o_y, o_z, o_ovf, o_err, e_x, e_y, e_z, e_ovf);
        end
        start_op(0, 1'b1, 0, fx(0.5), fx(0.5), 0);
        finish_op();
        checks++;
        if (lsb_err(o_z, PI / 4.0) > TOL || lsb_err(o_x, k * $sqrt(0.5)) > TOL ||
            lsb_err(o_y, 0.0) > TOL) begin
            failures++;
            $display("FAIL circ_vect_value got x=%0d y=%0d z=%0d exp x=%0d y~0 z=%0d",
                     o_x, o_y, o_z, fx(k * $sqrt(0.5)), fx(PI / 4.0));
        end
    endtask

    task automatic test_hyperbolic();
        logic signed [W-1:0] xi;
        real k, ch, sh;
        k  = gain(1, MAXI);
        xi = fx(1.207497);
        ch = ($exp(0.5) + $exp(-0.5)) / 2.0;
        sh = ($exp(0.5) - $exp(-0.5)) / 2.0;
        start_op(1, 1'b0, 0, xi, 0, fx(0.5));
        model(1, 1'b0, 0, xi, 0, fx(0.5));
        finish_op();
        checks++;
        if (lsb_err(o_x, $itor(xi) / SC * k * ch) > TOL || lsb_err(o_y, $itor(xi) / SC * k * sh) > TOL) begin
            failures++;
            $display("FAIL hyp_rot_value got x=%0d y=%0d exp x=%0d y=%0d",
                     o_x, o_y, fx($itor(xi) / SC * k * ch), fx($itor(xi) / SC * k * sh));
        end
        checks++;
        if ({o_x, o_y, o_z, o_ovf} !== {e_x[31:0], e_y[31:0], e_z[31:0], e_ovf} || o_lat != 29) begin
            failures++;
            $display("FAIL hyp_rot_exact got %0d %0d %0d ovf=%0b lat=%0d exp %0d %0d %0d ovf=%0b lat=29",
                     o_x, o_y, o_z, o_ovf, o_lat, e_x, e_y, e_z, e_ovf);
        end
    endtask

    task automatic test_linear();
        start_op(2, 1'b1, 0, fx(2.0), fx(1.5), 0);
        finish_op();
        checks++;
        if (o_x !== fx(2.0) || lsb_err(o_z, 0.75) > TOL || lsb_err(o_y, 0.0) > TOL) begin
            failures++;
            $display("FAIL lin_vect_value got x=%0d y=%0d z=%0d exp x=%0d y~0 z=%0d",
                     o_x, o_y, o_z, fx(2.0), fx(0.75));
        end
        start_op(2, 1'b0, 0, fx(1.5), 0, fx(0.5));
        finish_op();
        checks++;
        if (lsb_err(o_y, 0.75) > TOL || o_x !== fx(1.5) || lsb_err(o_z, 0.0) > TOL) begin
            failures++;
            $display("FAIL lin_rot_value got x=%0d y=%0d z=%0d exp x=%0d y=%0d z~0",
                     o_x, o_y, o_z, fx(1.5), fx(0.75));
        end
    endtask

    task automatic test_handshake_back_to_back();
        logic signed [W-1:0] hx, hy, hz;
        int bad;
        start_op(0, 1'b0, 5, fx(0.3), fx(-0.2), fx(0.4));
        hx = o_x; hy = o_y; hz = o_z;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_x !== hx || m_y !== hy || m_z !== hz) begin
                failures++;
                $display("FAIL backpressure_hold cycle=%0d got vld=%0b rdy=%0b x=%0d exp vld=1 rdy=0 x=%0d",
                         i, m_valid, s_ready, m_x, hx);
            end
        end
        finish_op();
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL consume_to_idle got vld=%0b rdy=%0b exp vld=0 rdy=1", m_valid, s_ready);
        end
        start_op(2, 1'b0, 3, fx(1.0), fx(0.25), fx(-0.5));
        model(2, 1'b0, 3, fx(1.0), fx(0.25), fx(-0.5));
        finish_op();
        checks++;
        if ({o_x, o_y, o_z} !== {e_x[31:0], e_y[31:0], e_z[31:0]} || o_lat != 4) begin
            failures++;
            $display("FAIL back_to_back got %0d %0d %0d lat=%0d exp %0d %0d %0d lat=4",
                     o_x, o_y, o_z, o_lat, e_x, e_y, e_z);
        end
    endtask

    task automatic test_reset_mid_run();
        s_valid = 1'b1; s_mode = 2'b00; s_vect = 1'b0; s_iters = '0;
        s_x = fx(0.6); s_y = fx(0.1); s_z = fx(0.3);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_ready, m_valid, m_ovf, m_err} !== 4'b0000 || {m_x, m_y, m_z} !== '0) begin
            failures++;
            $display("FAIL reset_mid_run got rdy=%0b vld=%0b x=%0h y=%0h z=%0h exp all 0",
                     s_ready, m_valid, m_x, m_y, m_z);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_release got rdy=%0b vld=%0b exp rdy=1 vld=0", s_ready, m_valid);
        end
    endtask

    task automatic test_corners();
        start_op(3, 1'b0, 7, fx(1.25), fx(-0.75), fx(2.5));
        finish_op();
        checks++;
        if (o_err !== 1'b1 || o_lat != 1 || o_x !== fx(1.25) || o_y !== fx(-0.75) || o_z !== fx(2.5)) begin
            failures++;
            $display("FAIL reserved_mode got err=%0b lat=%0d x=%0d y=%0d z=%0d exp err=1 lat=1 x=%0d y=%0d z=%0d",
                     o_err, o_lat, o_x, o_y, o_z, fx(1.25), fx(-0.75), fx(2.5));
        end
        start_op(0, 1'b1, 0, fx(3.9), fx(3.9), 0);
        model(0, 1'b1, 0, fx(3.9), fx(3.9), 0);
        finish_op();
        checks++;
        if (o_ovf !== 1'b1 || o_err !== 1'b0 || {o_x, o_y, o_z} !== {e_x[31:0], e_y[31:0], e_z[31:0]}) begin
            failures++;
            $display("FAIL overflow_flag got ovf=%0b err=%0b x=%0d exp ovf=1 err=0 x=%0d", o_ovf, o_err, o_x, e_x);
        end
        start_op(0, 1'b0, 1, fx(0.5), fx(0.25), fx(-0.3));
        model(0, 1'b0, 1, fx(0.5), fx(0.25), fx(-0.3));
        finish_op();
        checks++;
        if (o_lat != 2 || o_ovf !== 1'b0 || {o_x, o_y, o_z} !== {e_x[31:0], e_y[31:0], e_z[31:0]}) begin
            failures++;
            $display("FAIL single_step got lat=%0d x=%0d y=%0d z=%0d exp lat=2 x=%0d y=%0d z=%0d",
                     o_lat, o_x, o_y, o_z, e_x, e_y, e_z);
        end
    endtask

    task automatic test_random();
        int mode, iters, sh;
        bit vect;
        logic signed [W-1:0] x, y, z;
        for (int t = 0; t < 40; t++) begin
            mode  = $urandom_range(0, 2);
            vect  = 1'($urandom);
            iters = $urandom_range(0, 31);
            sh    = $urandom_range(1, 3);
            x = $signed($urandom) >>> sh;
            y = $signed($urandom) >>> sh;
            z = $signed($urandom) >>> sh;
            start_op(mode, vect, iters, x, y, z);
            model(mode, vect, iters, x, y, z);
            finish_op();
            checks++;
            if ({o_x, o_y, o_z, o_ovf, o_err} !== {e_x[31:0], e_y[31:0], e_z[31:0], e_ovf, e_err} ||
                o_lat != eff_n(iters) + 1) begin
                failures++;
                $display("FAIL random_op t=%0d mode=%0d vect=%0b n=%0d got %0d %0d %0d ovf=%0b lat=%0d exp %0d %0d %0d ovf=%0b lat=%0d",
                         t, mode, vect, iters, o_x, o_y, o_z, o_ovf, o_lat,
                         e_x, e_y, e_z, e_ovf, eff_n(iters) + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_circular();
        test_hyperbolic();
        test_linear();
        test_handshake_back_to_back();
        test_reset_mid_run();
        test_corners();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
